// File: rtl/shift_seq.sv
// shift_seq: iterative barrel-shift replacement that moves the operand one bit
// position per clock. A three-state FSM (IDLE -> SHIFT -> DONE -> IDLE) steps
// the result register and a down-counter, so an N-bit shift takes N SHIFT cycles.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   start          request, sampled only while ready=1
//   input_shift    operand, captured on an accepted start
//   shift_amount   bit count 0..31, captured on an accepted start
//   shift_type     operation: 0=LSL 1=LSR 2=ASR 3=ROR, captured on an accepted start
//   ready          high in IDLE only
//   busy           high in SHIFT only
//   done           one-cycle pulse, high in DONE only
//   output_shift   result register; holds until the next accepted start or reset
//   carry_out      last bit shifted out; 0 when the amount is 0
//   state_dbg      current FSM state encoding (0=IDLE 1=SHIFT 2=DONE)
//
// Handshake: a request is transferred on a rising edge where start=1 and
// ready=1. start is ignored while ready=0 (busy or done); the requester keeps
// or re-asserts start until it sees ready=1 at the edge. Completion is signalled
// by the single-cycle done pulse, and output_shift/carry_out are valid from
// that cycle until the next accepted request.
module shift_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input_shift,
  input  logic [4:0]       shift_amount,
  input  logic [1:0]       shift_type,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_shift,
  output logic             carry_out,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;

  state_t           state, state_nxt;
  logic [4:0]       count, count_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [WIDTH-1:0] shift_nxt;
  logic             carry_nxt;

  // All state lives here; the next values come from the combinational block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      count        <= 5'd0;
      op_q         <= 2'd0;
      output_shift <= '0;
      carry_out    <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      op_q         <= op_nxt;
      output_shift <= shift_nxt;
      carry_out    <= carry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    op_nxt    = op_q;
    shift_nxt = output_shift;
    carry_nxt = carry_out;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          shift_nxt = input_shift;
          count_nxt = shift_amount;
          op_nxt    = shift_type;
          carry_nxt = 1'b0;
          // A zero-length shift has nothing to iterate, so skip SHIFT.
          state_nxt = (shift_amount == 5'd0) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy      = 1'b1;
        count_nxt = count - 5'd1;
        case (op_q)
          OP_LSL: begin
            shift_nxt = {output_shift[WIDTH-2:0], 1'b0};
            carry_nxt = output_shift[WIDTH-1];
          end
          OP_LSR: begin
            shift_nxt = {1'b0, output_shift[WIDTH-1:1]};
            carry_nxt = output_shift[0];
          end
          OP_ASR: begin
            shift_nxt = {output_shift[WIDTH-1], output_shift[WIDTH-1:1]};
            carry_nxt = output_shift[0];
          end
          default: begin
            shift_nxt = {output_shift[0], output_shift[WIDTH-1:1]};
            carry_nxt = output_shift[0];
          end
        endcase
        // The step that takes the counter from 1 to 0 is the last one.
        if (count == 5'd1) state_nxt = S_DONE;
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, 32, data path width; only 32 is supported, and shift_amount is 5 bits wide.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 input_shift  input  32  operand; captured when start is accepted.
REQ-006 shift_amount  input  5  bit count 0..31; captured when start is accepted.
REQ-007 type  input  2  operation code: 0=LSL, 1=LSR, 2=ASR, 3=ROR; captured when start is accepted.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high in SHIFT only.
REQ-010 done  output  1  one-cycle pulse, high in DONE only.
REQ-011 output_shift  output  32  result register; holds its value until the next accepted start or reset.
REQ-012 carry_out  output  1  last bit shifted out; 0 when the amount is 0.

Function
REQ-013 The block SHALL be an iterative shifter that moves one bit position per clock cycle, using a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE, a start=1 at a rising edge SHALL be accepted:
- load the working register with input_shift;
- load the down-counter with shift_amount;
- latch type;
- clear carry_out.
REQ-015 Transitions on acceptance:
- amount != 0: go to SHIFT;
- amount = 0: go directly to DONE.
REQ-016 Each SHIFT cycle SHALL move the working register by one bit and decrement the counter.
- LSL: insert 0 at bit 0; carry_out = old bit 31.
- LSR: insert 0 at bit 31; carry_out = old bit 0.
- ASR: replicate old bit 31 into bit 31; carry_out = old bit 0.
- ROR: move old bit 0 into bit 31; carry_out = old bit 0.
REQ-017 SHIFT SHALL go to DONE on the cycle in which the counter is decremented from 1 to 0.
REQ-018 Latency: with the accept edge as cycle 0, done SHALL be high during cycle N+1 for amount N; N=0 gives done in cycle 1.
REQ-019 output_shift SHALL equal the final result no later than the cycle in which done is high.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-021 start while busy=1 or done=1 SHALL be ignored, with no effect on state, counter, or outputs; the requester must re-assert start once ready=1.
REQ-022 At most one of ready, busy, done SHALL be high in any cycle.
REQ-023 Changes on input_shift, shift_amount, or type after acceptance SHALL NOT affect the operation in progress.
REQ-024 The result of amount N SHALL match the single-step combinational shift of the same type by N, including the LSL/LSR zero-fill already used in the datapath.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL set:
- state = IDLE;
- output_shift = 0;
- carry_out = 0;
- counter = 0;
- ready = 1, busy = 0, done = 0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation without any done pulse; start asserted in the same cycle as reset SHALL be ignored.
REQ-027 After rst_n returns to 1, the first start SHALL be accepted at the next edge that has ready=1.

Verification
REQ-028 LSL, input_shift=0x00000001, amount=31 -> done in cycle 32, output_shift=0x80000000, carry_out=0; busy high in cycles 1..31.
REQ-029 ASR, input_shift=0x800000F0, amount=4 -> done in cycle 5, output_shift=0xF800000F, carry_out=0.
REQ-030 ROR, input_shift=0x00000001, amount=1 -> done in cycle 2, output_shift=0x80000000, carry_out=1.
REQ-031 LSR, input_shift=0xFFFFFFFF, amount=0 -> done in cycle 1, output_shift=0xFFFFFFFF, carry_out=0, busy never high.
REQ-032 LSL, input_shift=0x00000001, amount=10, plus a second start with different operands in cycle 3 -> second start ignored; done in cycle 11 with output_shift=0x00000400.
REQ-033 LSL, input_shift=0x00000001, amount=10, with rst_n=0 in cycle 5 -> cycle 6 shows ready=1, output_shift=0, carry_out=0; no done pulse follows.
